// File: rtl/vga_plot_arbiter.sv
// Shares the vga_adapter pixel-write port between NUM_REQ requesters (round-robin)
// and runs a full-screen clear sweep. Optional macro: VGA_PLOT_ARBITER_BOUNDS_CHECK_EN.
module vga_plot_arbiter #(
    parameter int                  NUM_REQ      = 3,
    parameter int                  X_W          = 8,
    parameter int                  Y_W          = 7,
    parameter int                  COLOUR_W     = 3,
    parameter int                  X_MAX        = 159,
    parameter int                  Y_MAX        = 119,
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = '0
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         clear_req,
    output logic                         clear_busy,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*X_W-1:0]       req_x,
    input  logic [NUM_REQ*Y_W-1:0]       req_y,
    input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
    output logic                         plot,
    output logic [X_W-1:0]               out_x,
    output logic [Y_W-1:0]               out_y,
    output logic [COLOUR_W-1:0]          out_colour,
`ifdef VGA_PLOT_ARBITER_BOUNDS_CHECK_EN
    output logic                         oob_err,
`endif
    output logic [1:0]                   grant_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        CLEAR = 2'd2
    } state_e;

    localparam logic [X_W-1:0] X_LAST   = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(Y_MAX);
    localparam logic [1:0]     LAST_REQ = 2'(NUM_REQ - 1);

    state_e                state_q, state_d;
    logic                  pending_q, pending_d;
    logic                  plot_q, plot_d;
    logic [X_W-1:0]        x_q, x_d;
    logic [Y_W-1:0]        y_q, y_d;
    logic [COLOUR_W-1:0]   colour_q, colour_d;
    logic [1:0]            gid_q, gid_d;
    logic [1:0]            ptr_q, ptr_d;
`ifdef VGA_PLOT_ARBITER_BOUNDS_CHECK_EN
    logic                  oob_q, oob_d;
`endif

    logic [2:0]            cand;
    logic                  win_found;
    logic [1:0]            win_idx;
    logic [X_W-1:0]        win_x;
    logic [Y_W-1:0]        win_y;
    logic [COLOUR_W-1:0]   win_colour;
    logic                  arb_en;
    logic                  accept;
    logic                  win_plots;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + 3'(k);
            if (cand >= 3'(NUM_REQ)) begin
                cand = cand - 3'(NUM_REQ);
            end
            if (!win_found && req_valid[cand[1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[1:0];
            end
        end
    end

    assign win_x      = req_x[win_idx*X_W +: X_W];
    assign win_y      = req_y[win_idx*Y_W +: Y_W];
    assign win_colour = req_colour[win_idx*COLOUR_W +: COLOUR_W];

    // Grants are withheld during reset, while a clear is pending and during the sweep.
    assign arb_en = reset_n && !pending_q && (state_q != CLEAR);
    assign accept = arb_en && win_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win_idx] = 1'b1;
        end
    end

`ifdef VGA_PLOT_ARBITER_BOUNDS_CHECK_EN
    assign win_plots = (win_x <= X_LAST) && (win_y <= Y_LAST);
`else
    assign win_plots = 1'b1;
`endif

    assign clear_busy = pending_q || (state_q == CLEAR);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        plot_d    = 1'b0;
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        gid_d     = gid_q;
        ptr_d     = ptr_q;
`ifdef VGA_PLOT_ARBITER_BOUNDS_CHECK_EN
        oob_d     = oob_q;
`endif

        if (clear_req && !clear_busy) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE, SERVE: begin
                if (accept) begin
                    state_d  = SERVE;
                    plot_d   = win_plots;
                    x_d      = win_x;
                    y_d      = win_y;
                    colour_d = win_colour;
                    gid_d    = win_idx;
                    ptr_d    = (win_idx == LAST_REQ) ? 2'd0 : win_idx + 2'd1;
`ifdef VGA_PLOT_ARBITER_BOUNDS_CHECK_EN
                    if (!win_plots) begin
                        oob_d = 1'b1;
                    end
`endif
                end else if (pending_q) begin
                    // Any accepted beat has already plotted; start the sweep at (0,0).
                    state_d   = CLEAR;
                    pending_d = 1'b0;
                    plot_d    = 1'b1;
                    x_d       = '0;
                    y_d       = '0;
                    colour_d  = CLEAR_COLOUR;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                plot_d = 1'b1;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        state_d = IDLE;
                        plot_d  = 1'b0;
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            plot_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            gid_q     <= '0;
            ptr_q     <= '0;
`ifdef VGA_PLOT_ARBITER_BOUNDS_CHECK_EN
            oob_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            plot_q    <= plot_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            gid_q     <= gid_d;
            ptr_q     <= ptr_d;
`ifdef VGA_PLOT_ARBITER_BOUNDS_CHECK_EN
            oob_q     <= oob_d;
`endif
        end
    end

    assign plot       = plot_q;
    assign out_x      = x_q;
    assign out_y      = y_q;
    assign out_colour = colour_q;
    assign grant_id   = gid_q;
`ifdef VGA_PLOT_ARBITER_BOUNDS_CHECK_EN
    assign oob_err    = oob_q;
`endif

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: the stimulus side models arbitration and the
// clear sweep and queues expected beats; a monitor pops and compares on every plot.
module tb_vga_plot_arbiter;

    localparam int N     = 3;
    localparam int SWEEP = 160 * 120;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        clear_req;
    logic        clear_busy;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [23:0] req_x;
    logic [20:0] req_y;
    logic [8:0]  req_colour;
    logic        plot;
    logic [7:0]  out_x;
    logic [6:0]  out_y;
    logic [2:0]  out_colour;
    logic [1:0]  grant_id;
`ifdef VGA_PLOT_ARBITER_BOUNDS_CHECK_EN
    logic        oob_err;
`endif

    logic [7:0]  px [3];
    logic [6:0]  py [3];
    logic [2:0]  pc [3];

    assign req_x      = {px[2], px[1], px[0]};
    assign req_y      = {py[2], py[1], py[0]};
    assign req_colour = {pc[2], pc[1], pc[0]};

    vga_plot_arbiter dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .plot       (plot),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_colour (out_colour),
`ifdef VGA_PLOT_ARBITER_BOUNDS_CHECK_EN
        .oob_err    (oob_err),
`endif
        .grant_id   (grant_id)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        int         gid;
    } beat_t;

    beat_t sb [$];
    int    checks   = 0;
    int    failures = 0;

    int    ptr_m    = 0;
    int    block_m  = 0;
    bit    prev_plot_m = 1'b0;
    bit    oob_m    = 1'b0;
    bit    inc_en   = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every plot must match the oldest expected beat.
    always @(negedge clock) begin
        beat_t e;
        if (plot === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_plot actual x=%0d y=%0d c=%0d expected=no plot at %0t",
                         out_x, out_y, out_colour, $time);
            end else begin
                e = sb.pop_front();
                chk("beat_xyc", int'({out_x, out_y, out_colour}), int'({e.x, e.y, e.c}));
                if (e.gid >= 0) begin
                    chk("grant_id", int'(grant_id), e.gid);
                end
            end
        end
    end

    // One clock of stimulus: predict ready/plot/busy, queue accepted beats, advance model.
    task automatic step();
        logic [2:0] er;
        int         win;
        int         c;
        bit         busy_m;
        bit         acc;
        bit         acc_plot;
        bit         start_clr;
        @(negedge clock);
        busy_m = (block_m > 0);
        er     = '0;
        win    = -1;
        if (reset_n && !busy_m) begin
            for (int k = 0; k < N; k++) begin
                c = (ptr_m + k) % N;
                if (win < 0 && req_valid[c]) win = c;
            end
        end
        if (win >= 0) er[win] = 1'b1;
        chk("req_ready", int'(req_ready), int'(er));
        chk("plot", int'(plot), int'(prev_plot_m || (block_m >= 1 && block_m <= SWEEP)));
        chk("clear_busy", int'(clear_busy), int'(busy_m));
`ifdef VGA_PLOT_ARBITER_BOUNDS_CHECK_EN
        chk("oob_err", int'(oob_err), int'(oob_m));
`endif
        acc      = (win >= 0);
        acc_plot = acc;
        if (acc) begin
`ifdef VGA_PLOT_ARBITER_BOUNDS_CHECK_EN
            if (px[win] > 8'd159 || py[win] > 7'd119) acc_plot = 1'b0;
`endif
            if (acc_plot) sb.push_back('{x: px[win], y: py[win], c: pc[win], gid: win});
        end
        start_clr = reset_n && clear_req && !busy_m;
        if (start_clr) begin
            for (int yy = 0; yy < 120; yy++) begin
                for (int xx = 0; xx < 160; xx++) begin
                    sb.push_back('{x: 8'(xx), y: 7'(yy), c: 3'b000, gid: -1});
                end
            end
        end
        @(posedge clock);
        #1;
        if (!reset_n) begin
            ptr_m       = 0;
            block_m     = 0;
            prev_plot_m = 1'b0;
            oob_m       = 1'b0;
            sb.delete();
        end else begin
            prev_plot_m = acc_plot;
            if (acc && !acc_plot) oob_m = 1'b1;
            if (acc) ptr_m = (win + 1) % N;
            if (block_m > 0) block_m--;
            if (start_clr) block_m = SWEEP + 1;
            if (acc && inc_en) begin
                px[win] = px[win] + 8'd1;
                py[win] = py[win] + 7'd1;
                pc[win] = pc[win] + 3'd1;
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        clear_req = 1'b0;
        req_valid = 3'b111;
        px[0] = 8'd11;  py[0] = 7'd1;  pc[0] = 3'd1;
        px[1] = 8'd50;  py[1] = 7'd40; pc[1] = 3'd2;
        px[2] = 8'd100; py[2] = 7'd80; pc[2] = 3'd4;
        @(posedge clock);
        #1;

        // Reset held with all requesters valid.
        repeat (3) step();
        chk("reset_out", int'({out_x, out_y, out_colour, grant_id}), 0);

        // Round-robin across three streaming requesters.
        reset_n = 1'b1;
        repeat (7) step();

        // Lone requester 2, then idle.
        inc_en    = 1'b0;
        req_valid = 3'b100;
        px[2] = 8'd10; py[2] = 7'd20; pc[2] = 3'b101;
        step();
        req_valid = 3'b000;
        repeat (3) step();

        // Clear while requester 1 streams; a second clear_req mid-sweep is ignored.
        inc_en    = 1'b1;
        req_valid = 3'b010;
        repeat (3) step();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (100) step();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (SWEEP + 10) step();

        // Reset part-way through a sweep abandons it.
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (5000) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (3) step();

        // Out-of-range x from requester 0.
        inc_en    = 1'b0;
        req_valid = 3'b001;
        px[0] = 8'd200; py[0] = 7'd5; pc[0] = 3'd2;
        step();
        req_valid = 3'b000;
        repeat (3) step();

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Shares the single pixel-write port of the vga_adapter (x, y, colour, plot) between NUM_REQ independent requesters. Typical requesters are the cursor/load path, the simulation change-drain path and the status overlay.
- Adds a built-in full-screen clear sweep that restores the background after reset or a board wipe.
- Sits between the control/simulation logic and vga_adapter. It guarantees at most one plot per cycle and no torn (x, y, colour) triples.

Parameters:
- NUM_REQ, 3, number of requester ports (2..4).
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COLOUR_W, 3, colour width.
- X_MAX, 159, last column swept by clear.
- Y_MAX, 119, last row swept by clear.
- CLEAR_COLOUR, 3'b000, colour written during clear.

Ports:
- clock  in  1  system clock (CLOCK_50).
- reset_n  in  1  synchronous, active-low reset.
- clear_req  in  1  single-cycle pulse: start a full-screen clear.
- clear_busy  out  1  high while the clear sweep is pending or running.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_x  in  NUM_REQ*X_W  packed x; requester i at bits [i*X_W +: X_W].
- req_y  in  NUM_REQ*Y_W  packed y, same packing.
- req_colour  in  NUM_REQ*COLOUR_W  packed colour, same packing.
- plot  out  1  write strobe to vga_adapter.
- out_x  out  X_W  registered x.
- out_y  out  Y_W  registered y.
- out_colour  out  COLOUR_W  registered colour.
- grant_id  out  2  index of the requester whose beat is on the output this cycle.

Behaviour:
- Reset, sampled on posedge clock with reset_n=0:
  - state=IDLE; plot=0; out_x/out_y/out_colour=0; grant_id=0; clear_busy=0; req_ready=0.
  - Round-robin pointer=0; pending-clear flag=0.
  - Reset mid-clear or mid-beat abandons the operation; no further plot is issued.
- States:
  - IDLE: no beat output.
  - SERVE: a requester beat is on the output.
  - CLEAR: sweep in progress.
- Arbitration (IDLE or SERVE, no pending clear):
  - Round-robin starting at the pointer. req_ready[i] is combinational and high only for the winner.
  - Transfer occurs when req_valid[i] & req_ready[i]. The payload is registered.
  - Next cycle: plot=1, out_* = payload, grant_id = i.
  - Pointer moves to (i+1) mod NUM_REQ.
  - Latency is exactly 1 cycle from accept to plot.
  - Throughput is 1 beat/cycle. Back-to-back beats from different requesters are allowed.
  - If no valid is present, the block returns to IDLE with plot=0.
- Requester rules:
  - Payload must stay stable while valid=1 and ready=0.
  - Valid must not drop before acceptance.
  - Violations are undefined.
- Starvation bound: a continuously valid requester is accepted within NUM_REQ cycles.
- Clear:
  - clear_req sets the pending flag; clear_busy rises the next cycle.
  - While pending, all req_ready=0. Any beat already accepted still plots.
  - CLEAR is entered the cycle after the last accepted beat plots (or immediately from IDLE).
- CLEAR sweep:
  - plot=1 every cycle with out_colour=CLEAR_COLOUR.
  - x increments 0..X_MAX, then wraps to 0 and y increments.
  - Last pixel is (X_MAX, Y_MAX). The sweep takes (X_MAX+1)*(Y_MAX+1) cycles: 19200 at defaults.
  - After the last pixel: clear_busy=0 and plot=0 the following cycle, state=IDLE, pointer unchanged.
- clear_req while clear_busy=1 is ignored: no restart, no queueing.
- clear_req coincident with an accept: the accept completes, then the clear takes over.
- Counter widths: x counter X_W bits, y counter Y_W bits. Comparison is against X_MAX/Y_MAX, never natural overflow.

Optional Feature:
- Macro: VGA_PLOT_ARBITER_BOUNDS_CHECK_EN.
- Defined:
  - An accepted beat with x>X_MAX or y>Y_MAX is consumed (ready still given) but plot stays 0 for that slot.
  - Extra output oob_err (1 bit) becomes sticky 1 until reset.
- Undefined:
  - Coordinates pass through unchecked; no oob_err port exists.

Test Plan:
1. Reset with req_valid=3'b111 held -> req_ready=0 and plot=0 throughout reset; first post-reset accept goes to requester 0; plot=1 next cycle with its x/y/colour.
2. All three valid continuously, distinct payloads -> grant_id sequence 0,1,2,0,1,2; plot high every cycle after the first; each out_* triple matches its requester.
3. Only requester 2 valid with (x=10, y=20, colour=3'b101) -> ready[2]=1 same cycle; plot next cycle with (10, 20, 5); then plot=0 in IDLE.
4. clear_req pulse while requester 1 is streaming -> in-flight beat plots; ready=0 for 19200 cycles; plot=1 each cycle from (0,0) to (159,119) with colour 0; clear_busy falls; requester 1 resumes.
5. Second clear_req 100 cycles into the sweep -> ignored; sweep length still 19200 cycles; reset_n=0 at cycle 5000 -> plot=0 and clear_busy=0 the next cycle.
6. With VGA_PLOT_ARBITER_BOUNDS_CHECK_EN, requester 0 sends x=200 -> accepted, no plot, oob_err=1 and sticky; without the macro -> plot=1 with out_x=200.
